// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: default geometry and
// the read-tag that rides alongside the RAM pipeline.
package ram_arb_pkg;
    localparam int AW_DEF = 5;
    localparam int DW_DEF = 8;
    localparam int NREQ   = 2;

    typedef struct packed {
        logic rd;
        logic id;
    } tag_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: rr_ptr names the requester that wins a tie.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        if (rr_ptr) begin
            if (valid[1])      grant = 2'b10;
            else if (valid[0]) grant = 2'b01;
        end else begin
            if (valid[0])      grant = 2'b01;
            else if (valid[1]) grant = 2'b10;
        end
    end
endmodule

// File: rtl/ram_arb2.sv
// Shares one single-port RAM between two requesters; read data is routed back
// to the issuer through a tag pipeline that tracks the RAM's 1-cycle latency.
module ram_arb2
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ-1:0] req_we,
    input  logic [AW-1:0]   req_addr0,
    input  logic [AW-1:0]   req_addr1,
    input  logic [DW-1:0]   req_wdata0,
    input  logic [DW-1:0]   req_wdata1,
    output logic [NREQ-1:0] rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            ram_en,
    output logic            ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata
);
    logic [NREQ-1:0] grant;
    logic            accept, win_id, win_we;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;

    logic            rr_ptr_q, rr_ptr_d;
    logic            ram_en_q, ram_en_d;
    logic            ram_we_q, ram_we_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
    tag_t            tag_a_q, tag_a_d, tag_b_q, tag_b_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;

    rr_arb2 u_arb (
        .valid  (req_valid),
        .rr_ptr (rr_ptr_q),
        .grant  (grant)
    );

    // Ready is forced low while reset is held so no handshake completes then.
    assign req_ready = grant & {NREQ{sys_rst_n}};
    assign accept    = |req_ready;
    assign win_id    = grant[1];
    assign win_we    = win_id ? req_we[1]  : req_we[0];
    assign win_addr  = win_id ? req_addr1  : req_addr0;
    assign win_wdata = win_id ? req_wdata1 : req_wdata0;

    always_comb begin
        rr_ptr_d    = accept ? ~win_id : rr_ptr_q;
        ram_en_d    = accept;
        ram_we_d    = accept & win_we;
        ram_addr_d  = accept ? win_addr  : ram_addr_q;
        ram_wdata_d = accept ? win_wdata : ram_wdata_q;
        tag_a_d.rd  = accept & ~win_we;
        tag_a_d.id  = win_id;
        tag_b_d     = tag_a_q;
        rsp_valid_d = '0;
        if (tag_b_q.rd) rsp_valid_d[tag_b_q.id] = 1'b1;
        rsp_rdata_d = tag_b_q.rd ? ram_rdata : rsp_rdata_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rr_ptr_q    <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            tag_a_q     <= '0;
            tag_b_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            tag_a_q     <= tag_a_d;
            tag_b_q     <= tag_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_ram_arb2.sv
// Directed bench for ram_arb2 with a behavioural 32x8 single-port RAM.
module tb_ram_arb2;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = '0, req_ready, req_we = '0, rsp_valid;
    logic [4:0] req_addr0 = '0, req_addr1 = '0, ram_addr;
    logic [7:0] req_wdata0 = '0, req_wdata1 = '0, rsp_rdata, ram_wdata, ram_rdata;
    logic       ram_en, ram_we;
    logic [7:0] mem [32];
    int         n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    ram_arb2 dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        logic [1:0] v;
        logic [1:0] exp_rdy;
        logic       exp_en;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        int c0, c1, k;
        logic got;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        ram_rdata = 8'h00;
        tbl[0] = '{2'b00, 2'b00, 1'b0};
        tbl[1] = '{2'b10, 2'b10, 1'b0};
        tbl[2] = '{2'b11, 2'b01, 1'b1};
        tbl[3] = '{2'b11, 2'b10, 1'b1};
        tbl[4] = '{2'b01, 2'b01, 1'b1};
        tbl[5] = '{2'b11, 2'b10, 1'b1};
        tbl[6] = '{2'b00, 2'b00, 1'b1};
        tbl[7] = '{2'b11, 2'b01, 1'b0};
        tbl[8] = '{2'b00, 2'b00, 1'b1};
        tbl[9] = '{2'b11, 2'b10, 1'b0};

        // reset values
        #2;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_wdata", 32'(ram_wdata), 0);
        do_reset();

        // arbitration table (reads only)
        req_we = 2'b00;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tbl%0d_ram_en", i), 32'(ram_en), 32'(tbl[i].exp_en));
            req_valid = tbl[i].v;
            req_addr0 = 5'(i);
            req_addr1 = 5'(i + 16);
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_rdy));
            cyc();
        end
        req_valid = '0;
        repeat (4) cyc();

        // requester 0 streams writes to every address
        req_we = 2'b01;
        for (int i = 0; i < 32; i++) begin
            req_valid = 2'b01;
            req_addr0 = 5'(i);
            req_wdata0 = 8'h10 + 8'(i);
            #1;
            chk($sformatf("wr%0d_ready", i), 32'(req_ready), 2'b01);
            cyc();
            chk($sformatf("wr%0d_en_we", i), {30'd0, ram_en, ram_we}, 2'b11);
            chk($sformatf("wr%0d_addr", i), 32'(ram_addr), 32'(i));
            chk($sformatf("wr%0d_wdata", i), 32'(ram_wdata), 32'h10 + 32'(i));
        end
        req_valid = '0;
        req_we = '0;
        cyc();
        chk("wr_end_en", 32'(ram_en), 0);

        // requester 1 reads addr 5
        req_valid = 2'b10;
        req_addr1 = 5'd5;
        #1;
        chk("rd5_ready", 32'(req_ready), 2'b10);
        cyc();
        req_valid = '0;
        chk("rd5_c1_rsp", 32'(rsp_valid), 0);
        cyc();
        chk("rd5_c2_rsp", 32'(rsp_valid), 0);
        cyc();
        chk("rd5_c3_rsp", 32'(rsp_valid), 2'b10);
        chk("rd5_data", 32'(rsp_rdata), 8'h15);
        cyc();
        chk("rd5_c4_rsp", 32'(rsp_valid), 0);

        // both valid continuously from reset
        do_reset();
        req_we = '0;
        req_addr0 = 5'd0;
        req_addr1 = 5'd0;
        req_valid = 2'b11;
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (req_ready[0]) c0++;
            if (req_ready[1]) c1++;
            chk($sformatf("alt%0d_ready", i), 32'(req_ready), (i % 2 == 0) ? 2'b01 : 2'b10);
            cyc();
        end
        req_valid = '0;
        chk("alt_cnt0", 32'(c0), 8);
        chk("alt_cnt1", 32'(c1), 8);
        repeat (4) cyc();

        // write then read the same address on consecutive cycles
        req_valid = 2'b01;
        req_we = 2'b01;
        req_addr0 = 5'd3;
        req_wdata0 = 8'hA5;
        cyc();
        req_valid = 2'b10;
        req_we = 2'b00;
        req_addr1 = 5'd3;
        #1;
        chk("raw_rd_ready", 32'(req_ready), 2'b10);
        cyc();
        req_valid = '0;
        got = 1'b0;
        k = 0;
        while (!got && k < 6) begin
            if (rsp_valid != 0) got = 1'b1;
            else begin cyc(); k++; end
        end
        chk("raw_seen", 32'(got), 1);
        chk("raw_rsp", 32'(rsp_valid), 2'b10);
        chk("raw_data", 32'(rsp_rdata), 8'hA5);
        repeat (3) cyc();

        // interleaved reads
        req_we = 2'b00;
        req_valid = 2'b01;
        req_addr0 = 5'd1;
        cyc();
        req_valid = 2'b10;
        req_addr1 = 5'd2;
        cyc();
        req_valid = '0;
        chk("il_c2_rsp", 32'(rsp_valid), 0);
        cyc();
        chk("il_first_rsp", 32'(rsp_valid), 2'b01);
        chk("il_first_data", 32'(rsp_rdata), 8'h11);
        cyc();
        chk("il_second_rsp", 32'(rsp_valid), 2'b10);
        chk("il_second_data", 32'(rsp_rdata), 8'h12);
        cyc();
        chk("il_after_rsp", 32'(rsp_valid), 0);

        // reset one cycle after a read is accepted
        req_valid = 2'b10;
        req_addr1 = 5'd7;
        cyc();
        chk("mid_en_before", 32'(ram_en), 1);
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_ready", 32'(req_ready), 0);
        chk("mid_ram_en", 32'(ram_en), 0);
        chk("mid_ram_we", 32'(ram_we), 0);
        chk("mid_ram_addr", 32'(ram_addr), 0);
        chk("mid_ram_wdata", 32'(ram_wdata), 0);
        chk("mid_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rsp_rdata", 32'(rsp_rdata), 0);
        req_valid = '0;
        repeat (2) cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("post%0d_rsp", i), 32'(rsp_valid), 0);
            chk($sformatf("post%0d_en", i), 32'(ram_en), 0);
        end
        req_valid = 2'b11;
        #1;
        chk("post_rr_ptr", 32'(req_ready), 2'b01);
        req_valid = '0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
